// File: rtl/thread_select_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : thread_select_unit_if
// Brief    : Fetch-side thread-select bus between the thread selector and fetch.
// Revision : 1.0
// ============================================================================
interface thread_select_unit_if #(
  parameter int NUM_THREADS = 4
);
  localparam int c_IDX_W = $clog2(NUM_THREADS);

  logic                     i_Stall;
  logic [NUM_THREADS-1:0]   i_thread_active;
  logic [NUM_THREADS-1:0]   i_icache_miss;
  logic [NUM_THREADS-1:0]   i_icache_fill;
  logic [2*NUM_THREADS-1:0] i_branch_mispredict;
  logic [c_IDX_W-1:0]       o_thread_choice;
  logic                     o_thread_valid;
  logic [NUM_THREADS-1:0]   o_blocked;

  modport master (
    output i_Stall, i_thread_active, i_icache_miss, i_icache_fill, i_branch_mispredict,
    input  o_thread_choice, o_thread_valid, o_blocked
  );

  modport slave (
    input  i_Stall, i_thread_active, i_icache_miss, i_icache_fill, i_branch_mispredict,
    output o_thread_choice, o_thread_valid, o_blocked
  );
endinterface
`default_nettype wire

// File: rtl/thread_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : thread_select_unit
// Brief    : Round-robin fetch thread selector skipping miss/flush-blocked threads.
// Revision : 1.0
// ============================================================================
module thread_select_unit #(
  parameter int NUM_THREADS    = 4,
  parameter int PENALTY_CYCLES = 3,
  parameter int CTR_WIDTH      = 3
) (
  input  wire logic             i_Clk,
  input  wire logic             i_Reset,
  thread_select_unit_if.slave   bus
);
  localparam int c_IDX_W = $clog2(NUM_THREADS);
  localparam logic [CTR_WIDTH-1:0] c_PENALTY = CTR_WIDTH'(PENALTY_CYCLES);
  localparam logic [c_IDX_W-1:0]   c_PTR_RST = c_IDX_W'(NUM_THREADS - 1);

  typedef enum logic [1:0] {
    ST_READY      = 2'd0,
    ST_MISS_WAIT  = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } state_t;

  state_t                 r_state [NUM_THREADS];
  logic [CTR_WIDTH-1:0]   r_ctr   [NUM_THREADS];
  state_t                 w_state_nxt [NUM_THREADS];
  logic [CTR_WIDTH-1:0]   w_ctr_nxt   [NUM_THREADS];
  logic [NUM_THREADS-1:0] w_elig;
  logic [NUM_THREADS-1:0] w_blocked_nxt;

  logic [c_IDX_W-1:0]     r_ptr;
  logic [c_IDX_W-1:0]     r_choice;
  logic                   r_valid;
  logic [NUM_THREADS-1:0] r_blocked;

  logic                   w_any;
  logic [c_IDX_W-1:0]     w_pick;
  logic [c_IDX_W-1:0]     w_idx;

  generate
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
      logic w_mp;
      assign w_mp = bus.i_branch_mispredict[2*t];

      // Mispredict beats miss beats fill; a zero penalty leaves the thread READY.
      always_comb begin
        w_state_nxt[t] = r_state[t];
        w_ctr_nxt[t]   = r_ctr[t];
        if (w_mp) begin
          w_state_nxt[t] = (PENALTY_CYCLES == 0) ? ST_READY : ST_FLUSH_WAIT;
          w_ctr_nxt[t]   = c_PENALTY;
        end else begin
          case (r_state[t])
            ST_READY: begin
              if (bus.i_icache_miss[t]) w_state_nxt[t] = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
              if (bus.i_icache_fill[t]) w_state_nxt[t] = ST_READY;
            end
            ST_FLUSH_WAIT: begin
              if (r_ctr[t] <= CTR_WIDTH'(1)) w_state_nxt[t] = ST_READY;
              else                           w_ctr_nxt[t]   = r_ctr[t] - CTR_WIDTH'(1);
            end
            default: w_state_nxt[t] = ST_READY;
          endcase
        end
      end

      assign w_blocked_nxt[t] = (w_state_nxt[t] != ST_READY);
      assign w_elig[t] = bus.i_thread_active[t] & (r_state[t] == ST_READY)
                       & ~bus.i_icache_miss[t] & ~w_mp;
    end
  endgenerate

  // Scan from farthest to nearest so the nearest eligible thread after ptr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_ptr;
    w_idx  = r_ptr;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      w_idx = r_ptr + c_IDX_W'(k);
      if (w_elig[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_state[t] <= ST_READY;
        r_ctr[t]   <= '0;
      end
      r_ptr     <= c_PTR_RST;
      r_choice  <= '0;
      r_valid   <= 1'b0;
      r_blocked <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_state[t] <= w_state_nxt[t];
        r_ctr[t]   <= w_ctr_nxt[t];
      end
      r_blocked <= w_blocked_nxt;
      if (!bus.i_Stall) begin
        r_valid <= w_any;
        if (w_any) begin
          r_choice <= w_pick;
          r_ptr    <= w_pick;
        end
      end
    end
  end

  assign bus.o_thread_choice = r_choice;
  assign bus.o_thread_valid  = r_valid;
  assign bus.o_blocked       = r_blocked;
endmodule
`default_nettype wire

// File: tb/tb_thread_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_select_unit
// Brief    : Randomized and directed bench against a behavioural selector model.
// Revision : 1.0
// ============================================================================
module tb_thread_select_unit;
  localparam int c_PEN = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  thread_select_unit_if #(.NUM_THREADS(4)) u_if ();

  thread_select_unit #(
    .NUM_THREADS(4), .PENALTY_CYCLES(c_PEN), .CTR_WIDTH(3)
  ) u_dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each thread owes a fill and/or some flush cycles; blocked while it owes anything.
  bit       m_miss_pend [4];
  int       m_flush_rem [4];
  int       m_last;
  bit       m_valid;
  int       m_choice;
  bit [3:0] m_blocked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin
      m_miss_pend[t] = 1'b0;
      m_flush_rem[t] = 0;
    end
    m_last = 3; m_valid = 1'b0; m_choice = 0; m_blocked = '0;
  endtask

  // Called at a negedge: drive, predict, check just after the rising edge, return at negedge.
  task automatic step(input bit stall, input bit [3:0] act, input bit [3:0] miss,
                      input bit [3:0] fill, input bit [7:0] bm);
    bit [3:0] elig;
    bit       found;
    int       c;
    u_if.i_Stall = stall;
    u_if.i_thread_active = act;
    u_if.i_icache_miss = miss;
    u_if.i_icache_fill = fill;
    u_if.i_branch_mispredict = bm;
    for (int t = 0; t < 4; t++)
      elig[t] = act[t] && !m_miss_pend[t] && (m_flush_rem[t] == 0) && !miss[t] && !bm[2*t];
    if (!stall) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!found && elig[c]) begin
          found = 1'b1; m_choice = c; m_last = c;
        end
      end
      m_valid = found;
    end
    for (int t = 0; t < 4; t++) begin
      if (bm[2*t]) begin
        m_flush_rem[t] = c_PEN; m_miss_pend[t] = 1'b0;
      end else if (m_flush_rem[t] > 0) begin
        m_flush_rem[t]--;
      end else if (m_miss_pend[t]) begin
        if (fill[t]) m_miss_pend[t] = 1'b0;
      end else if (miss[t]) begin
        m_miss_pend[t] = 1'b1;
      end
      m_blocked[t] = m_miss_pend[t] || (m_flush_rem[t] > 0);
    end
    @(posedge clk); #1;
    check("valid", 32'(u_if.o_thread_valid), 32'(m_valid));
    check("choice", 32'(u_if.o_thread_choice), 32'(m_choice));
    check("blocked", 32'(u_if.o_blocked), 32'(m_blocked));
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'hF, 4'h0, 4'h0, 8'h00);
  endtask

  task automatic random_run(input int n);
    bit [3:0] act, miss, fill;
    bit [7:0] bm;
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 4; t++) begin
        act[t]    = ($urandom_range(0, 9) != 0);
        miss[t]   = ($urandom_range(0, 7) == 0);
        fill[t]   = ($urandom_range(0, 3) == 0);
        bm[2*t]   = ($urandom_range(0, 15) == 0);
        bm[2*t+1] = 1'($urandom_range(0, 1));
      end
      step(($urandom_range(0, 7) == 0), act, miss, fill, bm);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(u_if.o_thread_valid), 32'd0);
    check({tag, "_choice"}, 32'(u_if.o_thread_choice), 32'd0);
    check({tag, "_blocked"}, 32'(u_if.o_blocked), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1;
    u_if.i_Stall = 1'b0; u_if.i_thread_active = '0; u_if.i_icache_miss = '0;
    u_if.i_icache_fill = '0; u_if.i_branch_mispredict = '0;
    model_reset();
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    quiet(6);                                        // plain rotation
    step(1'b0, 4'hF, 4'b0010, 4'h0, 8'h00);          // miss on thread 1
    quiet(4);
    step(1'b0, 4'hF, 4'h0, 4'b0010, 8'h00);          // fill thread 1
    quiet(4);
    step(1'b0, 4'hF, 4'h0, 4'h0, 8'b0001_0000);      // mispredict thread 2
    quiet(5);
    step(1'b0, 4'hF, 4'b1000, 4'h0, 8'h00);          // thread 3 miss
    quiet(1);
    step(1'b0, 4'hF, 4'h0, 4'h0, 8'b0100_0000);      // then mispredict
    step(1'b0, 4'hF, 4'h0, 4'b1000, 8'h00);          // fill during flush
    quiet(4);
    for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 4'h0, 4'h0, 8'h00);
    quiet(3);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 8'h00);
    quiet(2);

    random_run(400);

    step(1'b0, 4'hF, 4'h0, 4'h0, 8'h55);             // all threads flushing
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    quiet(5);
    random_run(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
